// File: rtl/mpu_context_loader.sv
// MPU context loader: fetches a 4-word PCB entry for a pid and writes it to the MPU registers.
module mpu_context_loader #(
    parameter logic [31:0] PCB_TABLE_BASE = 32'h0000_0100
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [3:0]  i_pid,
    input  logic        i_seg_fault,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_mpu_we,
    output logic [1:0]  o_mpu_write_addr,
    output logic [31:0] o_mpu_w_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault_load,
    output logic [3:0]  o_cur_pid
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PID_W  = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic                r_fault_pending;

    state_t              w_state_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [PID_W-1:0]    w_pid_nxt;
    logic                w_fault_nxt;
    logic                w_pending_nxt;
    logic [ADDR_W-1:0]   w_mem_addr_nxt;
    logic [IDX_W-1:0]    w_waddr_nxt;
    logic [31:0]         w_wdata_nxt;

    // Next-state, load bookkeeping and next output values.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_pid_nxt      = o_cur_pid;
        w_fault_nxt    = o_fault_load;
        w_pending_nxt  = r_fault_pending;
        w_mem_addr_nxt = o_mem_addr;
        w_waddr_nxt    = o_mpu_write_addr;
        w_wdata_nxt    = o_mpu_w_data;

        // A fault during a normal load is remembered; during a fault load it is dropped.
        if ((r_state != S_IDLE) && !o_fault_load && i_seg_fault) begin
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (i_seg_fault) begin
                    w_state_nxt = S_FETCH;
                    w_pid_nxt   = '0;
                    w_fault_nxt = 1'b1;
                    w_idx_nxt   = '0;
                end else if (i_start) begin
                    w_state_nxt = S_FETCH;
                    w_pid_nxt   = i_pid;
                    w_fault_nxt = 1'b0;
                    w_idx_nxt   = '0;
                end
            end
            S_FETCH: begin
                if (i_mem_ack) begin
                    w_state_nxt = S_WRITE;
                    w_wdata_nxt = i_mem_rdata;
                    w_waddr_nxt = r_idx;
                end
            end
            S_WRITE: begin
                if (r_idx == IDX_W'(3)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            S_DONE: begin
                if (w_pending_nxt) begin
                    w_state_nxt   = S_FETCH;
                    w_pid_nxt     = '0;
                    w_fault_nxt   = 1'b1;
                    w_idx_nxt     = '0;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_fault_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Address of the PCB word about to be fetched.
        if (w_state_nxt == S_FETCH) begin
            w_mem_addr_nxt = PCB_TABLE_BASE
                           + (ADDR_W'(w_pid_nxt) << 4)
                           + (ADDR_W'(w_idx_nxt) << 2);
        end
    end

    // State register and registered outputs.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_fault_pending  <= 1'b0;
            o_mem_req        <= 1'b0;
            o_mem_addr       <= '0;
            o_mpu_we         <= 1'b0;
            o_mpu_write_addr <= '0;
            o_mpu_w_data     <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_fault_load     <= 1'b0;
            o_cur_pid        <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_idx            <= w_idx_nxt;
            r_fault_pending  <= w_pending_nxt;
            o_mem_req        <= (w_state_nxt == S_FETCH);
            o_mem_addr       <= w_mem_addr_nxt;
            o_mpu_we         <= (w_state_nxt == S_WRITE);
            o_mpu_write_addr <= w_waddr_nxt;
            o_mpu_w_data     <= w_wdata_nxt;
            o_busy           <= (w_state_nxt != S_IDLE);
            o_done           <= (w_state_nxt == S_DONE);
            o_fault_load     <= w_fault_nxt;
            o_cur_pid        <= w_pid_nxt;
        end
    end

endmodule

// File: tb/tb_mpu_context_loader.sv
// Self-checking bench for mpu_context_loader: load-level model plus directed scenarios.
module tb_mpu_context_loader;

    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [3:0]  i_pid;
    logic        i_seg_fault;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_mpu_we;
    logic [1:0]  o_mpu_write_addr;
    logic [31:0] o_mpu_w_data;
    logic        o_busy;
    logic        o_done;
    logic        o_fault_load;
    logic [3:0]  o_cur_pid;

    mpu_context_loader #(.PCB_TABLE_BASE(BASE)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_pid(i_pid),
        .i_seg_fault(i_seg_fault), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_mpu_we(o_mpu_we),
        .o_mpu_write_addr(o_mpu_write_addr), .o_mpu_w_data(o_mpu_w_data),
        .o_busy(o_busy), .o_done(o_done), .o_fault_load(o_fault_load),
        .o_cur_pid(o_cur_pid)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic [3:0] pid;
        logic       fl;
    } load_t;

    load_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    w = 0;
    int    cur_len = 0;
    int    req_len[4];
    int    we_count = 0;
    int    done_count = 0;
    int    done_cyc = 0;
    int    acc = 0;
    int    rcnt = 0;
    int    stall_idx = -1;
    int    stall_n = 0;
    bit    ack_always = 1'b1;
    bit    prev_fire = 1'b0;
    logic [31:0] last_we_data = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] exp_addr(input logic [3:0] pid, input int widx);
        return BASE + 32'(pid) * 32'd16 + 32'(widx) * 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    always @(posedge i_clock) cyc <= cyc + 1;

    // Compare process against the queue of expected loads, then the memory responder.
    always @(negedge i_clock) begin
        if (i_reset) begin
            w = 0;
            cur_len = 0;
        end else if (!o_busy) begin
            chk("idle_quiet", 32'({o_mem_req, o_mpu_we, o_done}), 32'd0);
        end else if (q.size() == 0) begin
            chk("unexpected_busy", 32'(o_busy), 32'd0);
        end else begin
            chk("cur_pid", 32'(o_cur_pid), 32'(q[0].pid));
            chk("fault_load", 32'(o_fault_load), 32'(q[0].fl));
            if (o_mem_req) begin
                chk("mem_addr", o_mem_addr, exp_addr(q[0].pid, w));
                cur_len++;
            end
            if (o_mpu_we) begin
                chk("mpu_addr", 32'(o_mpu_write_addr), 32'(w));
                chk("mpu_data", o_mpu_w_data, mem_word(exp_addr(q[0].pid, w)));
                chk("we_after_ack", 32'(prev_fire), 32'd1);
                if (w < 4) req_len[w] = cur_len;
                cur_len = 0;
                last_we_data = o_mpu_w_data;
                w++;
                we_count++;
            end
            if (o_done) begin
                chk("done_words", 32'(w), 32'd4);
                done_count++;
                done_cyc = cyc;
                void'(q.pop_front());
                w = 0;
            end
        end
        if (ack_always) begin
            i_mem_ack = 1'b1;
        end else if (o_mem_req) begin
            i_mem_ack = (rcnt >= ((int'(o_mem_addr[3:2]) == stall_idx) ? stall_n : 0));
            rcnt++;
        end else begin
            i_mem_ack = 1'b0;
            rcnt = 0;
        end
        i_mem_rdata = mem_word(o_mem_addr);
        prev_fire = o_mem_req && i_mem_ack && !i_reset;
    end

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && done_count < target; i++) begin
            @(negedge i_clock);
            #1;
        end
        chk("done_timeout", 32'(done_count >= target), 32'd1);
    endtask

    task automatic wait_we(input int target);
        for (int i = 0; i < 200 && we_count < target; i++) begin
            @(negedge i_clock);
            #1;
        end
        chk("we_timeout", 32'(we_count >= target), 32'd1);
    endtask

    task automatic do_start(input logic [3:0] pid, input logic fl);
        @(negedge i_clock);
        #1;
        q.push_back('{pid: pid, fl: fl});
        i_pid = pid;
        i_start = 1'b1;
        @(posedge i_clock);
        #1;
        acc = cyc;
        i_start = 1'b0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_req"}, 32'(o_mem_req), 32'd0);
        chk({nm, "_addr"}, o_mem_addr, 32'd0);
        chk({nm, "_we"}, 32'(o_mpu_we), 32'd0);
        chk({nm, "_wdata"}, o_mpu_w_data, 32'd0);
        chk({nm, "_busy"}, 32'(o_busy), 32'd0);
        chk({nm, "_done"}, 32'(o_done), 32'd0);
        chk({nm, "_fl"}, 32'(o_fault_load), 32'd0);
        chk({nm, "_pid"}, 32'(o_cur_pid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_start = 1'b0;
        i_pid = '0;
        i_seg_fault = 1'b0;
        repeat (2) @(posedge i_clock);
        #1;
        check_zero("reset");
        @(negedge i_clock);
        #1;
        i_reset = 1'b0;
        repeat (2) @(negedge i_clock);

        // pid 2 with ack tied high
        do_start(4'd2, 1'b0);
        chk("first_addr", o_mem_addr, 32'h0000_0120);
        chk("busy_at_accept", 32'(o_busy), 32'd1);
        wait_done(1);
        chk("latency", 32'(done_cyc - acc + 1), 32'd9);
        chk("last_data", last_we_data, 32'h012C_FED3);
        chk("we_count_1", 32'(we_count), 32'd4);

        // word 1 acknowledged 3 cycles late
        repeat (3) @(negedge i_clock);
        ack_always = 1'b0;
        stall_idx = 1;
        stall_n = 3;
        do_start(4'd2, 1'b0);
        wait_done(2);
        chk("stall_len_w1", 32'(req_len[1]), 32'd4);
        chk("stall_len_w0", 32'(req_len[0]), 32'd1);
        chk("we_count_2", 32'(we_count), 32'd8);
        ack_always = 1'b1;
        stall_idx = -1;

        // seg_fault during pid 5 after word 1 -> chained kernel load
        repeat (3) @(negedge i_clock);
        q.push_back('{pid: 4'd5, fl: 1'b0});
        q.push_back('{pid: 4'd0, fl: 1'b1});
        @(negedge i_clock);
        #1;
        i_pid = 4'd5;
        i_start = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        wait_we(10);
        i_seg_fault = 1'b1;
        @(negedge i_clock);
        #1;
        i_seg_fault = 1'b0;
        wait_done(3);
        @(negedge i_clock);
        #1;
        chk("chain_req", 32'(o_mem_req), 32'd1);
        chk("chain_addr", o_mem_addr, 32'h0000_0100);
        chk("chain_fl", 32'(o_fault_load), 32'd1);
        chk("chain_pid", 32'(o_cur_pid), 32'd0);
        i_seg_fault = 1'b1;
        @(negedge i_clock);
        #1;
        i_seg_fault = 1'b0;
        wait_done(4);
        repeat (12) @(negedge i_clock);
        chk("chain_dones", 32'(done_count), 32'd4);
        chk("we_count_3", 32'(we_count), 32'd16);

        // start and seg_fault together in IDLE
        @(negedge i_clock);
        #1;
        q.push_back('{pid: 4'd0, fl: 1'b1});
        i_pid = 4'd3;
        i_start = 1'b1;
        i_seg_fault = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        i_seg_fault = 1'b0;
        chk("tie_pid", 32'(o_cur_pid), 32'd0);
        chk("tie_fl", 32'(o_fault_load), 32'd1);
        chk("tie_addr", o_mem_addr, 32'h0000_0100);
        wait_done(5);
        repeat (15) @(negedge i_clock);
        chk("tie_dones", 32'(done_count), 32'd5);

        // start while busy is ignored
        do_start(4'd7, 1'b0);
        repeat (3) @(negedge i_clock);
        #1;
        i_pid = 4'd9;
        i_start = 1'b1;
        @(negedge i_clock);
        #1;
        i_start = 1'b0;
        wait_done(6);
        repeat (10) @(negedge i_clock);
        chk("busy_start_we", 32'(we_count), 32'd24);
        chk("busy_start_dones", 32'(done_count), 32'd6);

        // reset between writes 2 and 3
        do_start(4'd6, 1'b0);
        wait_we(26);
        #2;
        i_reset = 1'b1;
        #1;
        check_zero("midreset");
        q.delete();
        repeat (2) @(negedge i_clock);
        #1;
        i_reset = 1'b0;
        repeat (10) @(negedge i_clock);
        chk("after_reset_we", 32'(we_count), 32'd26);
        chk("after_reset_dones", 32'(done_count), 32'd6);
        do_start(4'd1, 1'b0);
        chk("restart_addr", o_mem_addr, 32'h0000_0110);
        wait_done(7);
        chk("restart_we", 32'(we_count), 32'd30);

        repeat (3) @(negedge i_clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
